dmem_arbiter: RTL and testbench

Data-memory port controller for the MEM stage. Shares one variable-latency data-memory port (req/gnt issue, rvalid completion) between the pipeline MEM stage and an external requester (loader/debug). Sequences each access through a small FSM and drives `cpu_stall`, which freezes the IF/ID/EX/MEM pipeline registers until the CPU access completes. One transaction is outstanding at a time.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/rr_arb2.sv | 9 +
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the MEM-stage data-memory port controller.
package cpu_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, external-requester and memory-port signals around dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
);
    logic               cpu_re;
    logic               cpu_we;
    logic [A_WIDTH-1:0] cpu_addr;
    logic [D_WIDTH-1:0] cpu_wdata;
    logic [D_WIDTH-1:0] cpu_rdata;
    logic               cpu_stall;

    logic               ext_valid;
    logic               ext_we;
    logic [A_WIDTH-1:0] ext_addr;
    logic [D_WIDTH-1:0] ext_wdata;
    logic               ext_ready;
    logic               ext_rvalid;
    logic [D_WIDTH-1:0] ext_rdata;

    logic               mem_req;
    logic               mem_we;
    logic [A_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [D_WIDTH-1:0] mem_rdata;

    // Controller view: serves the requesters, masters the memory port.
    modport master (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_valid, ext_we, ext_addr, ext_wdata,
        output ext_ready, ext_rvalid, ext_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // Environment view: requesters and memory.
    modport slave (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_valid, ext_we, ext_addr, ext_wdata,
        input  ext_ready, ext_rvalid, ext_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    assign gnt[0] = req[0] & (~req[1] |  last);
    assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/dmem_arbiter.sv
// MEM-stage data-memory port controller: shares one req/gnt/rvalid port between
// the pipeline and an external requester, one transaction outstanding at a time.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.master bus
);
    state_t             state_q, state_d;
    owner_t             owner_q, last_q;
    logic               mem_req_q, mem_we_q;
    logic [A_WIDTH-1:0] mem_addr_q;
    logic [D_WIDTH-1:0] mem_wdata_q, cpu_rdata_q, ext_rdata_q;
    logic               cpu_req;
    logic [1:0]         gnt;

    assign cpu_req = bus.cpu_re | bus.cpu_we;

    rr_arb2 u_arb (
        .req  ({bus.ext_valid, cpu_req}),
        .last (last_q == OWN_EXT),
        .gnt  (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|gnt)          state_d = ST_REQ;
            ST_REQ:  if (bus.mem_gnt)    state_d = ST_RESP;
            ST_RESP: if (bus.mem_rvalid) state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Request fields are only loaded in IDLE, so they stay stable through REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_CPU;
            last_q      <= OWN_EXT;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt[1]) begin
                        owner_q     <= OWN_EXT;
                        last_q      <= OWN_EXT;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.ext_we;
                        mem_addr_q  <= bus.ext_addr;
                        mem_wdata_q <= bus.ext_wdata;
                    end else if (gnt[0]) begin
                        owner_q     <= OWN_CPU;
                        last_q      <= OWN_CPU;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.cpu_we;
                        mem_addr_q  <= bus.cpu_addr;
                        mem_wdata_q <= bus.cpu_wdata;
                    end
                end
                ST_REQ: if (bus.mem_gnt) mem_req_q <= 1'b0;
                ST_RESP: begin
                    if (bus.mem_rvalid) begin
                        if (owner_q == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
                        else                    ext_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.ext_ready  = ~rst & (state_q == ST_IDLE) & gnt[1];
    assign bus.ext_rvalid = ~rst & (state_q == ST_DONE) & (owner_q == OWN_EXT);
    // The pipeline advances only in the DONE cycle of its own access.
    assign bus.cpu_stall  = ~rst & cpu_req & ~((state_q == ST_DONE) & (owner_q == OWN_CPU));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; memory handshakes are driven per cycle.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   pass  = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.D_WIDTH(32), .A_WIDTH(32)) bus ();

    dmem_arbiter #(.D_WIDTH(32), .A_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.cpu_re = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_valid = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs(); cyc(); cyc(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        bus.cpu_re = 1; bus.ext_valid = 1;
        @(negedge clk);
        total++; if (bus.cpu_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.cpu_stall); else pass++;
        total++; if (bus.ext_ready !== 1'b0) $display("FAIL reset_ext_ready got %b want 0", bus.ext_ready); else pass++;
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 66'd0)
            $display("FAIL reset_mem got %b/%b/%h/%h want all 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); else pass++;
        total++; if ({bus.cpu_rdata, bus.ext_rdata, bus.ext_rvalid} !== 65'd0)
            $display("FAIL reset_rdata got %h/%h/%b want 0", bus.cpu_rdata, bus.ext_rdata, bus.ext_rvalid); else pass++;
        idle_inputs(); cyc(); rst = 0;
    endtask

    task automatic test_cpu_load();
        bus.cpu_re = 1; bus.cpu_addr = 32'h100;
        @(negedge clk);
        total++; if (bus.cpu_stall !== 1'b1 || bus.mem_req !== 1'b0)
            $display("FAIL load_c0 got stall=%b req=%b want 1/0", bus.cpu_stall, bus.mem_req); else pass++;
        cyc(); bus.mem_gnt = 1;
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_stall} !== {1'b1, 1'b0, 32'h100, 1'b1})
            $display("FAIL load_c1 got req=%b we=%b addr=%h stall=%b want 1/0/100/1", bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_stall); else pass++;
        cyc(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (bus.cpu_stall !== 1'b1 || bus.mem_req !== 1'b0)
            $display("FAIL load_c2 got stall=%b req=%b want 1/0", bus.cpu_stall, bus.mem_req); else pass++;
        cyc(); bus.mem_rvalid = 0; bus.mem_rdata = '0;
        @(negedge clk);
        total++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF)
            $display("FAIL load_c3 got stall=%b rdata=%h want 0/deadbeef", bus.cpu_stall, bus.cpu_rdata); else pass++;
        cyc(); bus.cpu_re = 0;
        @(negedge clk);
        total++; if (bus.cpu_rdata !== 32'hDEADBEEF || bus.mem_req !== 1'b0)
            $display("FAIL load_hold got rdata=%h req=%b want deadbeef/0", bus.cpu_rdata, bus.mem_req); else pass++;
    endtask

    task automatic test_cpu_store_wait();
        int n_stall = 0;
        bus.cpu_we = 1; bus.cpu_addr = 32'h200; bus.cpu_wdata = 32'h12345678;
        for (int i = 0; i < 7; i++) begin
            bus.mem_gnt = (i == 4); bus.mem_rvalid = (i == 5);
            @(negedge clk);
            if (bus.cpu_stall) n_stall++;
            if (i >= 1 && i <= 4) begin
                total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'h12345678})
                    $display("FAIL store_req_c%0d got req=%b we=%b addr=%h wdata=%h want 1/1/200/12345678",
                             i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); else pass++;
            end
            if (i == 6) begin
                total++; if (bus.cpu_stall !== 1'b0) $display("FAIL store_done_stall got %b want 0", bus.cpu_stall); else pass++;
            end
            cyc();
        end
        bus.cpu_we = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
        total++; if (n_stall !== 6) $display("FAIL store_stall_cycles got %0d want 6", n_stall); else pass++;
    endtask

    task automatic test_tie();
        do_reset();
        bus.cpu_re = 1; bus.cpu_addr = 32'h180;
        bus.ext_valid = 1; bus.ext_we = 0; bus.ext_addr = 32'h300;
        @(negedge clk);
        total++; if (bus.ext_ready !== 1'b0 || bus.cpu_stall !== 1'b1)
            $display("FAIL tie1_c0 got ready=%b stall=%b want 0/1", bus.ext_ready, bus.cpu_stall); else pass++;
        cyc(); bus.mem_gnt = 1;
        @(negedge clk);
        total++; if (bus.mem_addr !== 32'h180) $display("FAIL tie1_winner got addr=%h want 180", bus.mem_addr); else pass++;
        cyc(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h11;
        cyc(); bus.mem_rvalid = 0;
        @(negedge clk);
        total++; if ({bus.cpu_stall, bus.ext_ready, bus.cpu_rdata} !== {1'b0, 1'b0, 32'h11})
            $display("FAIL tie1_done got stall=%b ready=%b rdata=%h want 0/0/11", bus.cpu_stall, bus.ext_ready, bus.cpu_rdata); else pass++;
        cyc();
        @(negedge clk);
        total++; if (bus.ext_ready !== 1'b1 || bus.cpu_stall !== 1'b1)
            $display("FAIL tie2_c0 got ready=%b stall=%b want 1/1", bus.ext_ready, bus.cpu_stall); else pass++;
        cyc(); bus.ext_valid = 0; bus.mem_gnt = 1;
        @(negedge clk);
        total++; if ({bus.mem_addr, bus.mem_we, bus.ext_ready} !== {32'h300, 1'b0, 1'b0})
            $display("FAIL tie2_winner got addr=%h we=%b ready=%b want 300/0/0", bus.mem_addr, bus.mem_we, bus.ext_ready); else pass++;
        cyc(); bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
        cyc(); bus.mem_rvalid = 0;
        @(negedge clk);
        total++; if ({bus.ext_rvalid, bus.ext_rdata, bus.cpu_stall, bus.cpu_rdata} !== {1'b1, 32'h77, 1'b1, 32'h11})
            $display("FAIL tie2_done got rvalid=%b erdata=%h stall=%b crdata=%h want 1/77/1/11",
                     bus.ext_rvalid, bus.ext_rdata, bus.cpu_stall, bus.cpu_rdata); else pass++;
        cyc(); bus.cpu_re = 0;
    endtask

    task automatic test_ext_read();
        int n_rdy = 0, n_rv = 0, n_stall = 0;
        do_reset();
        bus.ext_valid = 1; bus.ext_we = 0; bus.ext_addr = 32'h40;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin bus.ext_valid = 0; bus.mem_gnt = 1; end
            if (i == 2) begin bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hA5A5A5A5; end
            if (i == 3) begin bus.mem_rvalid = 0; bus.mem_rdata = '0; end
            @(negedge clk);
            if (bus.ext_ready)  n_rdy++;
            if (bus.ext_rvalid) n_rv++;
            if (bus.cpu_stall)  n_stall++;
            if (i == 1) begin
                total++; if (bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0)
                    $display("FAIL ext_req got addr=%h we=%b want 40/0", bus.mem_addr, bus.mem_we); else pass++;
            end
            if (i == 3) begin
                total++; if (bus.ext_rvalid !== 1'b1 || bus.ext_rdata !== 32'hA5A5A5A5)
                    $display("FAIL ext_resp got rvalid=%b rdata=%h want 1/a5a5a5a5", bus.ext_rvalid, bus.ext_rdata); else pass++;
            end
            cyc();
        end
        total++; if (n_rdy !== 1 || n_rv !== 1 || n_stall !== 0)
            $display("FAIL ext_pulses got ready=%0d rvalid=%0d stall=%0d want 1/1/0", n_rdy, n_rv, n_stall); else pass++;
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        bus.cpu_re = 1; bus.cpu_addr = 32'h500;
        cyc(); bus.mem_gnt = 1;
        cyc(); bus.mem_gnt = 0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        total++; if ({bus.cpu_stall, bus.mem_req, bus.mem_addr, bus.cpu_rdata} !== 66'd0)
            $display("FAIL rst_resp_outputs got stall=%b req=%b addr=%h rdata=%h want all 0",
                     bus.cpu_stall, bus.mem_req, bus.mem_addr, bus.cpu_rdata); else pass++;
        bus.cpu_re = 0;
        cyc(); rst = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        total++; if (bus.ext_rvalid !== 1'b0) $display("FAIL stale_rvalid got %b want 0", bus.ext_rvalid); else pass++;
        cyc(); bus.mem_rvalid = 0; bus.mem_rdata = '0;
        @(negedge clk);
        total++; if ({bus.cpu_rdata, bus.ext_rdata, bus.mem_req, bus.cpu_stall} !== 66'd0)
            $display("FAIL stale_ignored got crdata=%h erdata=%h req=%b stall=%b want all 0",
                     bus.cpu_rdata, bus.ext_rdata, bus.mem_req, bus.cpu_stall); else pass++;
    endtask

    task automatic test_rw_both();
        bus.cpu_re = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h600; bus.cpu_wdata = 32'hCAFE;
        cyc(); bus.mem_gnt = 1;
        @(negedge clk);
        total++; if ({bus.mem_req, bus.mem_we, bus.mem_wdata} !== {1'b1, 1'b1, 32'hCAFE})
            $display("FAIL rw_both got req=%b we=%b wdata=%h want 1/1/cafe", bus.mem_req, bus.mem_we, bus.mem_wdata); else pass++;
        cyc(); bus.mem_gnt = 0; bus.mem_rvalid = 1;
        cyc(); bus.mem_rvalid = 0;
        @(negedge clk);
        total++; if (bus.cpu_stall !== 1'b0) $display("FAIL rw_both_done got stall=%b want 0", bus.cpu_stall); else pass++;
        cyc(); bus.cpu_re = 0; bus.cpu_we = 0;
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_cpu_store_wait();
        test_tie();
        test_ext_read();
        test_reset_in_resp();
        test_rw_both();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
